// File: rtl/idelay_ctrl_pkg.sv
// Shared types for the IDELAY tap controller.
// Tap width, FSM state encoding, command mode encoding.
package idelay_ctrl_pkg;

    localparam int TAP_W = 9;
    localparam int TMR_W = 16;

    typedef enum logic {
        MODE_LOAD = 1'b0,
        MODE_STEP = 1'b1
    } mode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_VTC_OFF,
        S_LOAD_PULSE,
        S_STEP_CE,
        S_STEP_GAP,
        S_SETTLE,
        S_CHECK,
        S_VTC_ON,
        S_DONE
    } state_e;

endpackage

// File: rtl/idelay_tap_ctrl_if.sv
// Command/status handshake between a requester and the tap controller.
// The controller takes the slave side.
interface idelay_tap_ctrl_if;
    import idelay_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [TAP_W-1:0] cmd_tap;
    logic             cmd_mode;
    logic             done;
    logic             error;
    logic [TAP_W-1:0] cur_tap;

    modport master (
        output cmd_valid, cmd_tap, cmd_mode,
        input  cmd_ready, done, error, cur_tap
    );

    modport slave (
        input  cmd_valid, cmd_tap, cmd_mode,
        output cmd_ready, done, error, cur_tap
    );

endinterface

// File: rtl/idelay_wait_timer.sv
// Loadable down-counter with a zero flag; holds at zero.
// Shared by the VTC-off wait and the post-update settle wait.
module idelay_wait_timer
    import idelay_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/idelay_tap_ctrl.sv
// IDELAY tap controller: drops EN_VTC, loads or walks the tap,
// settles, verifies the readback and restores VTC tracking.
module idelay_tap_ctrl
    import idelay_ctrl_pkg::*;
#(
    parameter int VTC_WAIT_CYCLES = 10,
    parameter int SETTLE_CYCLES   = 2,
    parameter int MAX_TAP         = 511
) (
    input  logic             clk_i,
    input  logic             rst_i,
    idelay_tap_ctrl_if.slave cmd,
    output logic             en_vtc_o,
    output logic             load_o,
    output logic             ce_o,
    output logic             inc_o,
    output logic [TAP_W-1:0] cntvaluein_o,
    input  logic [TAP_W-1:0] cntvalueout_i
);

    localparam logic [TMR_W-1:0] VTC_LD = TMR_W'(VTC_WAIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] SET_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W:0]   MAX_T  = (TAP_W + 1)'(MAX_TAP);

    state_e           state_q;
    mode_e            mode_q;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] cur_q;
    logic [TAP_W-1:0] cin_q;
    logic             en_vtc_q;
    logic             load_q;
    logic             ce_q;
    logic             inc_q;
    logic             done_q;
    logic             err_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;

    // Timer reloads in every state except while it is counting, so it
    // enters VTC_OFF and SETTLE already primed with the right count.
    assign tmr_load = !((state_q == S_SETTLE) ||
                        (state_q == S_VTC_OFF && !tmr_zero));
    assign tmr_val  = (state_q == S_IDLE) ? VTC_LD : SET_LD;

    idelay_wait_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_LOAD;
            tap_q    <= '0;
            cur_q    <= '0;
            cin_q    <= '0;
            en_vtc_q <= 1'b1;
            load_q   <= 1'b0;
            ce_q     <= 1'b0;
            inc_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        tap_q  <= cmd.cmd_tap;
                        mode_q <= mode_e'(cmd.cmd_mode);
                        if ({1'b0, cmd.cmd_tap} > MAX_T) begin
                            err_q   <= 1'b1;
                            state_q <= S_VTC_ON;
                        end else begin
                            err_q    <= 1'b0;
                            en_vtc_q <= 1'b0;
                            inc_q    <= cmd.cmd_mode &&
                                        (cmd.cmd_tap > cur_q);
                            state_q  <= S_VTC_OFF;
                        end
                    end
                end
                S_VTC_OFF: begin
                    if (tmr_zero) begin
                        if (mode_q == MODE_LOAD) begin
                            load_q  <= 1'b1;
                            ce_q    <= 1'b1;
                            cin_q   <= tap_q;
                            cur_q   <= tap_q;
                            state_q <= S_LOAD_PULSE;
                        end else if (cur_q == tap_q) begin
                            state_q <= S_SETTLE;
                        end else begin
                            ce_q    <= 1'b1;
                            state_q <= S_STEP_CE;
                        end
                    end
                end
                S_LOAD_PULSE: begin
                    load_q  <= 1'b0;
                    ce_q    <= 1'b0;
                    cin_q   <= '0;
                    state_q <= S_SETTLE;
                end
                S_STEP_CE: begin
                    ce_q    <= 1'b0;
                    cur_q   <= inc_q ? cur_q + 1'b1 : cur_q - 1'b1;
                    state_q <= S_STEP_GAP;
                end
                S_STEP_GAP: begin
                    if (cur_q == tap_q) begin
                        state_q <= S_SETTLE;
                    end else begin
                        ce_q    <= 1'b1;
                        state_q <= S_STEP_CE;
                    end
                end
                S_SETTLE: begin
                    if (tmr_zero) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cntvalueout_i != tap_q) begin
                        err_q <= 1'b1;
                        cur_q <= cntvalueout_i;
                    end
                    en_vtc_q <= 1'b1;
                    state_q  <= S_VTC_ON;
                end
                S_VTC_ON: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign cmd.done      = done_q;
    assign cmd.error     = err_q;
    assign cmd.cur_tap   = cur_q;
    assign en_vtc_o      = en_vtc_q;
    assign load_o        = load_q;
    assign ce_o          = ce_q;
    assign inc_o         = inc_q;
    assign cntvaluein_o  = cin_q;

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// Bench for idelay_tap_ctrl: two instances (MAX_TAP 511 and 300),
// each attached to a delay-element model, checked against a latency model.
module tb_idelay_tap_ctrl;

    localparam int V = 10;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    idelay_tap_ctrl_if if0 ();
    idelay_tap_ctrl_if if1 ();

    logic       drv_valid;
    logic [8:0] drv_tap;
    logic       drv_mode;
    bit         sel;
    bit         stuck;

    assign if0.cmd_valid = drv_valid & ~sel;
    assign if1.cmd_valid = drv_valid & sel;
    assign if0.cmd_tap   = drv_tap;
    assign if1.cmd_tap   = drv_tap;
    assign if0.cmd_mode  = drv_mode;
    assign if1.cmd_mode  = drv_mode;

    logic       en0, ld0, ce0, inc0, en1, ld1, ce1, inc1;
    logic [8:0] cin0, cout0, cin1, cout1, mval0, mval1;

    idelay_tap_ctrl #(
        .VTC_WAIT_CYCLES (V),
        .SETTLE_CYCLES   (S),
        .MAX_TAP         (511)
    ) u_dut0 (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd           (if0),
        .en_vtc_o      (en0),
        .load_o        (ld0),
        .ce_o          (ce0),
        .inc_o         (inc0),
        .cntvaluein_o  (cin0),
        .cntvalueout_i (cout0)
    );

    idelay_tap_ctrl #(
        .VTC_WAIT_CYCLES (V),
        .SETTLE_CYCLES   (S),
        .MAX_TAP         (300)
    ) u_dut1 (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd           (if1),
        .en_vtc_o      (en1),
        .load_o        (ld1),
        .ce_o          (ce1),
        .inc_o         (inc1),
        .cntvaluein_o  (cin1),
        .cntvalueout_i (cout1)
    );

    // Delay-element models: CE with LOAD loads, CE alone steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mval0 <= '0;
            mval1 <= '0;
        end else begin
            if (ce0) mval0 <= ld0 ? cin0 : (inc0 ? mval0 + 9'd1 : mval0 - 9'd1);
            if (ce1) mval1 <= ld1 ? cin1 : (inc1 ? mval1 + 9'd1 : mval1 - 9'd1);
        end
    end
    assign cout0 = stuck ? 9'd0 : mval0;
    assign cout1 = mval1;

    logic       o_ready, o_done, o_err, o_en, o_ld, o_ce, o_inc;
    logic [8:0] o_cur, o_cin, o_cout;
    assign o_ready = sel ? if1.cmd_ready : if0.cmd_ready;
    assign o_done  = sel ? if1.done      : if0.done;
    assign o_err   = sel ? if1.error     : if0.error;
    assign o_cur   = sel ? if1.cur_tap   : if0.cur_tap;
    assign o_en    = sel ? en1  : en0;
    assign o_ld    = sel ? ld1  : ld0;
    assign o_ce    = sel ? ce1  : ce0;
    assign o_inc   = sel ? inc1 : inc0;
    assign o_cin   = sel ? cin1 : cin0;
    assign o_cout  = sel ? cout1 : cout0;

    int n_cmp = 0;
    int n_err = 0;
    int ref_cur [2];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_ready", o_ready, 1);
        check("rst_en_vtc", o_en, 1);
        check("rst_load", o_ld, 0);
        check("rst_ce", o_ce, 0);
        check("rst_inc", o_inc, 0);
        check("rst_cntin", o_cin, 0);
        check("rst_cur", o_cur, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_err, 0);
    endtask

    // Issues one command and checks it against the timing/result model.
    task automatic run_cmd(input logic [8:0] tap, input logic mode,
                           input bit noise);
        int cur_e, lat_e, ce_e, ld_e, fin_e, maxt, k;
        int lat, ce_n, ld_n, ld_at, vtc_bad, inc_bad, w;
        bit err_e, inc_e, bad;
        maxt  = sel ? 300 : 511;
        cur_e = ref_cur[sel];
        bad   = int'(tap) > maxt;
        err_e = bad;
        inc_e = 1'b0;
        if (bad) begin
            lat_e = 1; ce_e = 0; ld_e = 0; fin_e = cur_e;
        end else if (!mode) begin
            lat_e = V + S + 3; ce_e = 1; ld_e = 1; fin_e = int'(tap);
        end else begin
            k = (int'(tap) > cur_e) ? int'(tap) - cur_e : cur_e - int'(tap);
            lat_e = V + 2 * k + S + 2; ce_e = k; ld_e = 0;
            inc_e = int'(tap) > cur_e; fin_e = int'(tap);
        end
        if (!bad && stuck && tap != 0) begin
            err_e = 1'b1; fin_e = 0;
        end
        w = 0;
        while (!o_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("ready_idle", o_ready, 1);
        drv_valid = 1'b1; drv_tap = tap; drv_mode = mode;
        @(posedge clk); #1;
        if (!noise) drv_valid = 1'b0;
        lat = 0; ce_n = 0; ld_n = 0; ld_at = -1; vtc_bad = 0; inc_bad = 0;
        for (int n = 0; n <= lat_e + 40; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (noise) begin
                drv_tap = 9'($urandom); drv_mode = 1'($urandom);
            end
            if (o_ce) ce_n++;
            if (o_ld && o_ce) begin ld_n++; ld_at = n; end
            if (o_ce && mode && o_inc !== inc_e) inc_bad++;
            if (o_en !== ((n >= lat_e - 1) ? 1'b1 : 1'b0)) vtc_bad++;
            if (o_done) begin lat = n; break; end
        end
        drv_valid = 1'b0;
        check("done_latency", lat, lat_e);
        check("ce_pulses", ce_n, ce_e);
        check("load_ce_pulses", ld_n, ld_e);
        if (ld_e == 1) check("load_cycle", ld_at, V);
        check("en_vtc_window", vtc_bad, 0);
        if (mode && !bad) check("inc_stable", inc_bad, 0);
        check("error_at_done", o_err, err_e);
        check("cur_tap_at_done", o_cur, fin_e);
        if (!bad && !stuck) check("cntvalueout", o_cout, tap);
        @(posedge clk); #1;
        check("done_one_cycle", o_done, 0);
        check("ready_after", o_ready, 1);
        ref_cur[sel] = fin_e;
    endtask

    initial begin
        int ce_n;
        logic [8:0] t;
        rst = 1'b1; drv_valid = 1'b0; drv_tap = '0; drv_mode = 1'b0;
        sel = 1'b0; stuck = 1'b0;
        ref_cur[0] = 0; ref_cur[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;

        run_cmd(9'd50, 1'b0, 1'b0);
        run_cmd(9'd60, 1'b1, 1'b0);
        run_cmd(9'd55, 1'b1, 1'b1);
        run_cmd(9'd55, 1'b1, 1'b0);
        run_cmd(9'd0, 1'b0, 1'b0);
        run_cmd(9'd3, 1'b1, 1'b0);
        run_cmd(9'd511, 1'b0, 1'b1);
        run_cmd(9'd508, 1'b1, 1'b0);
        run_cmd(9'd511, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_cmd(9'($urandom_range(0, 511)), 1'($urandom),
                    bit'($urandom));
        end

        stuck = 1'b1;
        run_cmd(9'd50, 1'b0, 1'b0);
        stuck = 1'b0;
        run_cmd(9'd20, 1'b0, 1'b0);

        sel = 1'b1;
        run_cmd(9'd100, 1'b0, 1'b0);
        run_cmd(9'd400, 1'b0, 1'b1);
        run_cmd(9'd300, 1'b1, 1'b0);
        run_cmd(9'd301, 1'b1, 1'b0);
        sel = 1'b0;

        // Reset in the middle of a 10-step walk.
        t = (ref_cur[0] > 501) ? 9'(ref_cur[0] - 10) : 9'(ref_cur[0] + 10);
        drv_valid = 1'b1; drv_tap = t; drv_mode = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        ce_n = 0;
        for (int n = 0; n < 100 && ce_n < 3; n++) begin
            @(posedge clk); #1;
            if (o_ce) ce_n++;
        end
        check("walk_reached_step3", ce_n, 3);
        #2 rst = 1'b1;
        #1;
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        ref_cur[0] = 0; ref_cur[1] = 0;
        run_cmd(9'd7, 1'b1, 1'b0);
        run_cmd(9'd2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
